uart_tx_fifo: RTL

//  Next-generation UART transmitter for the jacaranda-8 peripheral bus. Adds a parametrised

---
 rtl/uart_tx_fifo.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write FIFO and runtime frame format.
// Frames run back-to-back while data is queued; serial line idles high, LSB first.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DIV_W = 32,
    localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_en,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic [1:0]       data_len,
    input  logic [1:0]       parity_mode,
    input  logic             stop2,
    input  logic [DIV_W-1:0] clk_count_bit,
    output logic             tx,
    output logic             busy_flag,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e           state_q, state_d;
    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             overflow_q;
    logic             push, pop;
    logic [7:0]       head;
    logic [7:0]       head_mask;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             stop_idx_q, stop_idx_d;
    logic [2:0]       last_bit_q;
    logic             par_en_q, par_bit_q, stop2_q;
    logic [DIV_W-1:0] cnt_q, cnt_d, div_eff;
    logic             bit_done;

    assign full       = (level_q == LVL_W'(DEPTH));
    assign empty      = (level_q == '0);
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign busy_flag  = (state_q != StIdle) || !empty;
    assign push       = wr_en && !full;
    assign head       = mem[rd_ptr_q];
    // Keep only the bits that will actually be sent (5..8) for the parity sum.
    assign head_mask  = 8'hFF >> (2'd3 - data_len);

    // A divisor of 0 behaves as 1; >= keeps a mid-frame divisor decrease from hanging.
    assign div_eff  = (clk_count_bit == '0) ? DIV_W'(1) : clk_count_bit;
    assign bit_done = (cnt_q >= div_eff - DIV_W'(1));

    // FIFO storage; no reset needed, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

    // FIFO pointers, level and overflow pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= wr_en && full;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Frame state, bit timer and per-frame configuration latched at pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            last_bit_q <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            if (pop) begin
                last_bit_q <= {1'b1, data_len};
                par_en_q   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                par_bit_q  <= (^(head & head_mask)) ^ (parity_mode == 2'b10);
                stop2_q    <= stop2;
            end
        end
    end

    // Next-state logic: bit sequencing, pops at idle or at the last stop-bit boundary.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        cnt_d      = (state_q == StIdle || bit_done) ? '0 : cnt_q + DIV_W'(1);
        unique case (state_q)
            StIdle: begin
                if (tx_en && !empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    bit_idx_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (bit_done) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == last_bit_q) begin
                        stop_idx_d = 1'b0;
                        state_d    = par_en_q ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (bit_done) begin
                    stop_idx_d = 1'b0;
                    state_d    = StStop;
                end
            end
            StStop: begin
                if (bit_done) begin
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else if (tx_en && !empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Serial line driven from the current state.
    always_comb begin
        tx = 1'b1;
        unique case (state_q)
            StStart:  tx = 1'b0;
            StData:   tx = shift_q[0];
            StParity: tx = par_bit_q;
            default:  tx = 1'b1;
        endcase
    end

endmodule
